rf_write_arbiter: RTL

- Shares the single register-file write port (WE3/RA3/WD3) between two requesters:
  - Port A: pipeline writeback. Cannot be back-pressured.
  - Port B: multicycle unit, e.g. a multiplier or load sequencer.
- B requests are buffered in a small in-order queue and drained when A is idle.
- The block exports a pending-write mask for the hazard unit and a starvation stall request for the pipeline.
- It sits between the writeback stage and the register file.

---
 rtl/rf_write_arbiter_if.sv | 32 +++
 rtl/rf_write_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - register-file write port sharing bus: writeback A, queued B, RF write side
interface rf_write_arbiter_if #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4,
  parameter int DEPTH      = 2
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic                    A_VALID;
  logic [AMOUNT_REG-1:0]   A_ADDR;
  logic [SIZE-1:0]         A_DATA;
  logic                    B_VALID;
  logic [AMOUNT_REG-1:0]   B_ADDR;
  logic [SIZE-1:0]         B_DATA;
  logic                    B_READY;
  logic                    WE3;
  logic [AMOUNT_REG-1:0]   RA3;
  logic [SIZE-1:0]         WD3;
  logic [2**AMOUNT_REG-1:0] PENDING;
  logic [CNTW-1:0]         QUEUE_COUNT;
  logic                    A_STALL;

  modport master (
    output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    input  B_READY, WE3, RA3, WD3, PENDING, QUEUE_COUNT, A_STALL
  );

  modport slave (
    input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    output B_READY, WE3, RA3, WD3, PENDING, QUEUE_COUNT, A_STALL
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the RF write port between writeback (A) and a queued multicycle unit (B)
module rf_write_arbiter #(
  parameter int SIZE         = 32,
  parameter int AMOUNT_REG   = 4,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  rf_write_arbiter_if.slave bus
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SCW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [AMOUNT_REG-1:0] NO_REG = '1;

  logic [AMOUNT_REG-1:0]    q_addr [DEPTH];
  logic [SIZE-1:0]          q_data [DEPTH];
  logic [CNTW-1:0]          q_count;
  logic [AMOUNT_REG-1:0]    n_addr [DEPTH];
  logic [SIZE-1:0]          n_data [DEPTH];
  logic [CNTW-1:0]          n_count;
  logic [SCW-1:0]           starve_cnt;
  logic                     we_q;
  logic [AMOUNT_REG-1:0]    ra_q;
  logic [SIZE-1:0]          wd_q;
  logic                     stall_q;
  logic                     q_empty;
  logic                     b_ready;
  logic                     a_issue;
  logic                     pop;
  logic                     b_push;
  logic                     head_cancel;
  logic [2**AMOUNT_REG-1:0] pending;

  assign q_empty     = (q_count == '0);
  assign b_ready     = (q_count < CNTW'(DEPTH));
  assign a_issue     = bus.A_VALID && (bus.A_ADDR != NO_REG);
  assign pop         = !a_issue && !q_empty;
  assign b_push      = bus.B_VALID && b_ready && (bus.B_ADDR != NO_REG);
  assign head_cancel = a_issue && !q_empty && (q_addr[0] == bus.A_ADDR);

  // Queue is kept compacted with the head in slot 0: survivors of the pop and
  // of A cancellation slide down in order, then the (younger) B entry appends.
  always_comb begin
    logic [CNTW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_addr[i] = q_addr[i];
      n_data[i] = q_data[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNTW'(i) < q_count) && !(pop && (i == 0)) &&
          !(a_issue && (q_addr[i] == bus.A_ADDR))) begin
        n_addr[idx[IW-1:0]] = q_addr[i];
        n_data[idx[IW-1:0]] = q_data[i];
        idx = idx + CNTW'(1);
      end
    end
    if (b_push) begin
      n_addr[idx[IW-1:0]] = bus.B_ADDR;
      n_data[idx[IW-1:0]] = bus.B_DATA;
      idx = idx + CNTW'(1);
    end
    n_count = idx;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNTW'(i) < q_count) begin
        pending[q_addr[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_count    <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      ra_q       <= '0;
      wd_q       <= '0;
      stall_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      q_count <= n_count;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= n_addr[i];
        q_data[i] <= n_data[i];
      end

      if (a_issue) begin
        we_q <= 1'b1;
        ra_q <= bus.A_ADDR;
        wd_q <= bus.A_DATA;
      end else if (!q_empty) begin
        we_q <= 1'b1;
        ra_q <= q_addr[0];
        wd_q <= q_data[0];
      end else begin
        we_q <= 1'b0;
      end

      // Remaining branches only run when A won against a non-empty queue.
      stall_q <= 1'b0;
      if (q_empty || pop || head_cancel) begin
        starve_cnt <= '0;
      end else if (starve_cnt == SCW'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        stall_q    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + SCW'(1);
      end
    end
  end

  assign bus.B_READY     = b_ready;
  assign bus.WE3         = we_q;
  assign bus.RA3         = ra_q;
  assign bus.WD3         = wd_q;
  assign bus.PENDING     = pending;
  assign bus.QUEUE_COUNT = q_count;
  assign bus.A_STALL     = stall_q;
endmodule
